// File: rtl/cpu_phase_pkg.sv
// Shared phase encodings and width constant for the CPU phase controller.
// Performance counters in cpu_phase_ctrl are built only when CPU_PHASE_PERF_EN is defined.
package cpu_phase_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } phase_e;

  // IDLE and ERR are the only phases that are not working on an instruction.
  function automatic logic is_busy(input phase_e p);
    return (p != IDLE) && (p != ERR);
  endfunction

endpackage

// File: rtl/cpu_phase_wait_timer.sv
// Memory-wait counter: cleared on entry to a waiting phase, counts not-ready cycles,
// and flags expiry on the not-ready cycle that brings the count to MEM_TIMEOUT.
module wait_timer #(
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [WAIT_W:0]   LIMIT    = (WAIT_W+1)'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {1'b0, WAIT_ONE};

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (cnt_en) begin
      count_q <= count_q + WAIT_ONE;
    end
  end

  // Looking at the incremented value lets the controller leave on the cycle the limit is hit.
  assign expired = cnt_en && (count_inc == LIMIT);

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Multi-cycle CPU phase sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// Define CPU_PHASE_PERF_EN to build the cycle_cnt/stall_cnt performance counters.
module cpu_phase_ctrl
  import cpu_phase_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               reg_wr,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               pc_en,
  output logic               ir_en,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               reg_wr_en,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  phase_e           state_q, state_d;
  logic             load_q, store_q, reg_wr_q;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] instr_q;

  logic wait_clr, wait_en, wait_expired;
  logic ir_s, rd_s, wr_s, pc_s, rw_s;

  // Count only while the ready signal the current phase depends on is low.
  assign wait_en = ((state_q == FETCH) && !imem_ready) ||
                   ((state_q == MEM)   && !dmem_ready);

  assign wait_clr = ((state_d == FETCH) && (state_q != FETCH)) ||
                    ((state_d == MEM)   && (state_q != MEM));

  wait_timer #(
    .WAIT_W     (WAIT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr),
    .cnt_en (wait_en),
    .expired(wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    ir_s      = 1'b0;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    pc_s      = 1'b0;
    rw_s      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          ir_s    = 1'b1;
          state_d = DECODE;
        end else if (wait_expired) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = (load_q || store_q) ? MEM : WB;
      MEM: begin
        // A store wins if decode flagged both.
        wr_s = store_q;
        rd_s = load_q && !store_q;
        if (dmem_ready) begin
          state_d = WB;
        end else if (wait_expired) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      WB: begin
        pc_s    = 1'b1;
        rw_s    = reg_wr_q && !store_q;
        state_d = run ? FETCH : IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      if (state_q == DECODE) begin
        load_q   <= is_load;
        store_q  <= is_store;
        reg_wr_q <= reg_wr;
      end
      if (state_q == WB) instr_q <= instr_q + CNT_ONE;
    end
  end

  // Strobes are masked by reset so they drop in the reset cycle itself.
  assign ir_en       = ir_s && !rst;
  assign mem_rd_en   = rd_s && !rst;
  assign mem_wr_en   = wr_s && !rst;
  assign pc_en       = pc_s && !rst;
  assign reg_wr_en   = rw_s && !rst;
  assign phase       = state_q;
  assign busy        = is_busy(state_q);
  assign timeout_err = timeout_q;
  assign instr_cnt   = instr_q;

`ifdef CPU_PHASE_PERF_EN
  logic [CNT_W-1:0] cycle_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (busy)    cycle_q <= cycle_q + CNT_ONE;
      if (wait_en) stall_q <= stall_q + CNT_ONE;
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/cpu_phase_ctrl.md
CPU_PHASE_CTRL -- requirements
Module: cpu_phase_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the instruction and performance counters.
REQ-002 SHALL have parameter WAIT_W, default 4, width of the memory-wait counter.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, number of consecutive not-ready cycles that is treated as a fault.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as listed:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- run  in  1  enables instruction sequencing.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- is_load  in  1  decoded lw.
- is_store  in  1  decoded sw.
- reg_wr  in  1  decoded register-write request.
- phase  out  3  current state encoding.
- busy  out  1  state is neither IDLE nor ERR.
- pc_en  out  1  PC update strobe.
- ir_en  out  1  instruction register load strobe.
- mem_rd_en  out  1  data read request.
- mem_wr_en  out  1  data write request.
- reg_wr_en  out  1  register file write strobe.
- timeout_err  out  1  sticky fault flag.
- instr_cnt  out  CNT_W  retired instruction count.
- cycle_cnt  out  CNT_W  busy-cycle count (perf only).
- stall_cnt  out  CNT_W  memory-wait cycle count (perf only).

Function
REQ-005 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5 and ERR=6; phase SHALL equal the current state.
REQ-006 SHALL move from IDLE to FETCH on the first cycle in which run=1; otherwise it SHALL stay in IDLE.
REQ-007 SHALL hold FETCH while imem_ready=0; when imem_ready=1 it SHALL assert ir_en for exactly that cycle and then go to DECODE.
REQ-008 SHALL spend one cycle in DECODE, register is_load, is_store and reg_wr on the DECODE->EXEC edge, and ignore later changes to those inputs until the next DECODE.
REQ-009 SHALL spend one cycle in EXEC, then go to MEM if the latched is_load or is_store is set, otherwise to WB.
REQ-010 SHALL, in MEM, hold mem_rd_en (load) or mem_wr_en (store) high every cycle until dmem_ready=1, then go to WB; if both latched flags are set, store SHALL take priority.
REQ-011 SHALL, in WB, for one cycle: assert pc_en=1, set reg_wr_en equal to the latched reg_wr (forced 0 for a store), and increment instr_cnt; the next state SHALL be FETCH if run=1, else IDLE.
REQ-012 SHALL deassert every strobe output outside the states named in REQ-007, REQ-010 and REQ-011; pc_en and reg_wr_en SHALL each pulse at most once per instruction.
REQ-013 SHALL have a minimum latency, with ready signals held high, of 4 cycles for non-memory instructions and 5 cycles for memory instructions.
REQ-014 SHALL clear the wait counter on entry to FETCH or MEM and increment it on each cycle in which the awaited ready signal is 0.
REQ-015 SHALL, when the wait counter reaches MEM_TIMEOUT, go to ERR and set timeout_err=1.
REQ-016 SHALL, in ERR, hold all strobes at 0 and ignore run; only rst SHALL leave ERR.
REQ-017 SHALL, when run drops mid-instruction, complete the current instruction through WB and then go to IDLE.
REQ-018 SHALL let instr_cnt wrap modulo 2^CNT_W without a flag.

Reset
REQ-019 SHALL, on rst=1 at a posedge from any state, go to IDLE, clear all counters, timeout_err and the latched flags, and drive every strobe to 0 in the same cycle.
REQ-020 SHALL give reset priority over run, ready and timeout in the same cycle.

Configuration
REQ-021 SHALL, with CPU_PHASE_PERF_EN defined: increment cycle_cnt on every cycle busy=1, and increment stall_cnt on every FETCH/MEM cycle with the awaited ready signal 0; both SHALL wrap.
REQ-022 SHALL, without CPU_PHASE_PERF_EN: keep the cycle_cnt and stall_cnt ports and tie them to 0, with no counter logic instantiated.

Structure
REQ-023 SHALL place the state encodings and the phase-width constant in the shared package cpu_phase_pkg.
REQ-024 SHALL implement the wait counter and its timeout compare as one sub-module, wait_timer (clear, count-enable, WAIT_W, MEM_TIMEOUT, expired output).

Verification
REQ-025 SHALL cover an add with ready held high: phases 1,2,3,5; pc_en and reg_wr_en pulse in cycle 4; instr_cnt goes 0->1.
REQ-026 SHALL cover lw with dmem_ready low for 3 cycles: mem_rd_en high for 4 cycles, WB in cycle 8, reg_wr_en=1.
REQ-027 SHALL cover sw with reg_wr=1 input: mem_wr_en pulses, reg_wr_en stays 0, pc_en=1.
REQ-028 SHALL cover imem_ready held low with MEM_TIMEOUT=15: ERR after 15 wait cycles, timeout_err=1, strobes stay 0 until rst.
REQ-029 SHALL cover rst asserted in MEM: next cycle phase=0, counters 0, mem_wr_en=0.
REQ-030 SHALL cover run dropped in DECODE: the instruction retires (instr_cnt+1), then phase=0; with CPU_PHASE_PERF_EN defined, cycle_cnt=4.
